// File: rtl/demorgan_sweep_checker.sv
// Sweeps the demorgan block through all four {A,B} vectors and checks its eight outputs.
// Define DEMORGAN_SWEEP_GRAY_EN to drive the vectors in Gray order (00,01,11,10) instead of binary.
module demorgan_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             in_nA,
  input  logic             in_nB,
  input  logic             in_nAandnB,
  input  logic             in_AandB,
  input  logic             in_nAandB,
  input  logic             in_nAornB,
  input  logic             in_AorB,
  input  logic             in_nAorB,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       fail_mask,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} stateT;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_PASS   = 8'(NUM_PASSES - 1);

  stateT      state;
  logic [1:0] vecIdx;
  logic [7:0] passCnt;
  logic [3:0] settleCnt;
  logic [7:0] golden;
  logic [7:0] observed;
  logic [7:0] diff;

  function automatic logic [1:0] vecOf(input logic [1:0] idx);
`ifdef DEMORGAN_SWEEP_GRAY_EN
    return {idx[1], idx[1] ^ idx[0]};
`else
    return idx;
`endif
  endfunction

  // Golden values are derived from the vector currently on the drive pins.
  assign golden = {~(drv_a | drv_b), drv_a | drv_b, ~drv_a | ~drv_b, ~(drv_a & drv_b),
                   drv_a & drv_b, ~drv_a & ~drv_b, ~drv_b, ~drv_a};
  assign observed = {in_nAorB, in_AorB, in_nAornB, in_nAandB,
                     in_AandB, in_nAandnB, in_nB, in_nA};
  assign diff = golden ^ observed;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      vecIdx           <= 2'd0;
      passCnt          <= 8'd0;
      settleCnt        <= 4'd0;
      drv_a            <= 1'b0;
      drv_b            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      fail_mask        <= 8'd0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state            <= SETTLE;
            vecIdx           <= 2'd0;
            passCnt          <= 8'd0;
            settleCnt        <= SETTLE_LOAD;
            {drv_a, drv_b}   <= vecOf(2'd0);
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_count        <= '0;
            fail_mask        <= 8'd0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'd0;
          end
        end
        SETTLE: begin
          if (settleCnt <= 4'd1) state <= CHECK;
          else settleCnt <= settleCnt - 4'd1;
        end
        CHECK: begin
          if (diff != 8'd0) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            fail_mask <= fail_mask | diff;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= {drv_a, drv_b};
            end
          end
          settleCnt <= SETTLE_LOAD;
          if (vecIdx != 2'd3) begin
            vecIdx         <= vecIdx + 2'd1;
            {drv_a, drv_b} <= vecOf(vecIdx + 2'd1);
            state          <= SETTLE;
          end else if (passCnt != LAST_PASS) begin
            passCnt        <= passCnt + 8'd1;
            vecIdx         <= 2'd0;
            {drv_a, drv_b} <= vecOf(2'd0);
            state          <= SETTLE;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          done           <= 1'b1;
          busy           <= 1'b0;
          pass           <= (err_count == '0) && (fail_mask == 8'd0);
          {drv_a, drv_b} <= 2'b00;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Two checker instances (short and long sweeps) each wrapped around a fault-injectable demorgan model.
module tb_demorgan_sweep_checker;

  logic       clk;
  logic       reset;
  logic [1:0] startV;
  logic [1:0] drvA, drvB, busyV, doneV, passV, ffvV;
  logic [7:0] errV   [2];
  logic [7:0] maskV  [2];
  logic [1:0] ffvecV [2];
  logic [7:0] s0     [2];
  logic [7:0] s1     [2];
  logic [7:0] dmOut  [2];

  int checks = 0;
  int errors = 0;

  // Demorgan reference written with integer arithmetic on A,B in {0,1}.
  function automatic logic [7:0] goldenOf(input logic [1:0] v);
    int a, b;
    logic [7:0] g;
    a = int'(v[1]);
    b = int'(v[0]);
    g[0] = (a == 0);
    g[1] = (b == 0);
    g[2] = (a + b == 0);
    g[3] = (a * b == 1);
    g[4] = (a * b == 0);
    g[5] = (a + b < 2);
    g[6] = (a + b > 0);
    g[7] = (a + b == 0);
    return g;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gDut
    assign dmOut[g] = (goldenOf({drvA[g], drvB[g]}) & ~s0[g]) | s1[g];
    demorgan_sweep_checker #(
      .SETTLE_CYCLES(g == 0 ? 1 : 2),
      .NUM_PASSES   (g == 0 ? 1 : 70),
      .ERR_W        (8)
    ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (startV[g]),
      .drv_a           (drvA[g]),
      .drv_b           (drvB[g]),
      .in_nA           (dmOut[g][0]),
      .in_nB           (dmOut[g][1]),
      .in_nAandnB      (dmOut[g][2]),
      .in_AandB        (dmOut[g][3]),
      .in_nAandB       (dmOut[g][4]),
      .in_nAornB       (dmOut[g][5]),
      .in_AorB         (dmOut[g][6]),
      .in_nAorB        (dmOut[g][7]),
      .busy            (busyV[g]),
      .done            (doneV[g]),
      .pass            (passV[g]),
      .err_count       (errV[g]),
      .fail_mask       (maskV[g]),
      .first_fail_valid(ffvV[g]),
      .first_fail_vec  (ffvecV[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One run on instance d with the given stuck-at-0/stuck-at-1 masks, checked against the model.
  task automatic applyStimulus(input int d, input logic [7:0] m0, input logic [7:0] m1, input bit midStart);
    logic [1:0] ord [4];
    logic [1:0] vec;
    logic [7:0] diff, expMask;
    logic [1:0] expFfvec;
    int sp, np, runLen, cnt, expErr, j, drvErr, busyErr;
    bit expFfv;
`ifdef DEMORGAN_SWEEP_GRAY_EN
    ord = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
    ord = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif
    sp = (d == 0) ? 1 : 2;
    np = (d == 0) ? 1 : 70;
    runLen = np * 4 * (sp + 1) + 1;
    s0[d] = m0;
    s1[d] = m1 & ~m0;
    cnt = 0; expMask = 8'd0; expFfv = 1'b0; expFfvec = 2'b00;
    for (int p = 0; p < np; p++) begin
      for (int v = 0; v < 4; v++) begin
        vec = ord[v];
        diff = goldenOf(vec) ^ ((goldenOf(vec) & ~s0[d]) | s1[d]);
        if (diff != 8'd0) begin
          cnt++;
          expMask |= diff;
          if (!expFfv) begin
            expFfv = 1'b1;
            expFfvec = vec;
          end
        end
      end
    end
    expErr = (cnt > 255) ? 255 : cnt;

    @(negedge clk);
    startV[d] = 1'b1;
    @(posedge clk);
    #1 startV[d] = 1'b0;
    j = 0; drvErr = 0; busyErr = 0;
    @(negedge clk);
    while (!doneV[d] && j < runLen + 20) begin
      if (j < runLen - 1) begin
        if ({drvA[d], drvB[d]} !== ord[(j / (sp + 1)) % 4]) drvErr++;
        if (busyV[d] !== 1'b1) busyErr++;
      end
      if (midStart) startV[d] = (j == 3);
      @(negedge clk);
      j++;
    end
    startV[d] = 1'b0;
    checkOutput("latency", j, runLen);
    checkOutput("drvSequence", drvErr, 0);
    checkOutput("busyDuringRun", busyErr, 0);
    checkOutput("busyAtDone", busyV[d], 1'b0);
    checkOutput("errCount", errV[d], expErr);
    checkOutput("failMask", maskV[d], expMask);
    checkOutput("firstFailValid", ffvV[d], expFfv);
    checkOutput("firstFailVec", ffvecV[d], expFfvec);
    checkOutput("pass", passV[d], (cnt == 0));
    @(negedge clk);
    checkOutput("donePulseWidth", doneV[d], 1'b0);
    checkOutput("drvIdle", {drvA[d], drvB[d]}, 2'b00);
    checkOutput("errHold", errV[d], expErr);
  endtask

  initial begin
    int nDone;
    startV = 2'b00;
    for (int d = 0; d < 2; d++) begin
      s0[d] = 8'd0;
      s1[d] = 8'd0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetFlags", {busyV, doneV, passV, ffvV, drvA, drvB}, 12'd0);
    checkOutput("resetErr", {errV[0], errV[1]}, 16'd0);
    checkOutput("resetMask", {maskV[0], maskV[1]}, 16'd0);
    checkOutput("resetFfvec", {ffvecV[0], ffvecV[1]}, 4'd0);
    reset = 1'b0;

    applyStimulus(0, 8'h00, 8'h00, 1'b0);
    applyStimulus(0, 8'h80, 8'h00, 1'b0);
    applyStimulus(0, 8'h00, 8'h08, 1'b0);
    applyStimulus(0, 8'h40, 8'h00, 1'b1);
    applyStimulus(1, 8'h00, 8'h08, 1'b0);
    applyStimulus(1, 8'hFF, 8'h00, 1'b1);
    applyStimulus(1, 8'h00, 8'h00, 1'b0);

    // Abort a run mid-flight and confirm it leaves no trace.
    s0[1] = 8'hFF; s1[1] = 8'h00;
    @(negedge clk);
    startV[1] = 1'b1;
    @(negedge clk);
    startV[1] = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abortFlags", {busyV[1], doneV[1], passV[1], ffvV[1], drvA[1], drvB[1]}, 6'd0);
    checkOutput("abortErr", errV[1], 8'd0);
    checkOutput("abortMask", maskV[1], 8'd0);
    nDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (doneV[1]) nDone++;
    end
    checkOutput("abortNoDone", nDone, 0);
    applyStimulus(1, 8'h00, 8'h00, 1'b0);

    for (int k = 0; k < 12; k++) begin
      int d;
      logic [7:0] r0, r1;
      d = (k % 3 == 2) ? 1 : 0;
      r0 = 8'($urandom) & 8'($urandom);
      r1 = 8'($urandom) & 8'($urandom) & 8'($urandom);
      applyStimulus(d, r0, r1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
